// File: rtl/rps_pkg.sv
// Shared types and helpers for the rock-paper-scissors match scorer.
package rps_pkg;

    typedef enum logic [2:0] {
        StIdle = 3'd0,
        StPlay = 3'd1,
        StWon  = 3'd2,
        StLost = 3'd3,
        StDraw = 3'd4
    } state_e;

    typedef enum logic [1:0] {
        RES_TIE  = 2'd0,
        RES_WIN  = 2'd1,
        RES_LOSE = 2'd2
    } result_e;

    // Bits needed to hold 0..max_val, never less than one.
    function automatic int unsigned score_width(input int unsigned max_val);
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction

    // A round where both win and lose are asserted scores as a tie.
    function automatic result_e decode_result(input logic win, input logic lose);
        if (win && !lose) return RES_WIN;
        if (lose && !win) return RES_LOSE;
        return RES_TIE;
    endfunction

endpackage

// File: rtl/rps_edge_detect.sv
// One-cycle rising-edge pulse of a level input; previous value resets to 0.
module rps_edge_detect (
    input  logic clock,
    input  logic reset_n,
    input  logic level,
    output logic rise
);

    logic prev_q;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            prev_q <= 1'b0;
        end else begin
            prev_q <= level;
        end
    end

    assign rise = level & ~prev_q;

endmodule

// File: rtl/rps_match_scorer.sv
// Best-of match scorer: counts round results, decides the match and drives status/LED.
module rps_match_scorer
    import rps_pkg::*;
#(
    parameter int unsigned WINS_TO_MATCH = 3,
    parameter int unsigned MAX_ROUNDS    = 9,
    parameter int unsigned BLINK_DIV     = 6_000_000
) (
    input  logic                                   clock,
    input  logic                                   reset_n,
    input  logic                                   start_match,
    input  logic                                   result_valid,
    input  logic                                   win_in,
    input  logic                                   lose_in,
    output logic [score_width(WINS_TO_MATCH)-1:0]  player_score,
    output logic [score_width(WINS_TO_MATCH)-1:0]  cpu_score,
    output logic [score_width(MAX_ROUNDS)-1:0]     round_count,
    output logic                                   round_strobe,
    output logic                                   match_active,
    output logic                                   match_won,
    output logic                                   match_lost,
    output logic                                   match_draw,
    output logic                                   result_led,
    output logic                                   protocol_err
);

    localparam int unsigned SW = score_width(WINS_TO_MATCH);
    localparam int unsigned RW = score_width(MAX_ROUNDS);
    localparam int unsigned BW = score_width(BLINK_DIV - 1);

    localparam logic [SW-1:0] WinsMax   = SW'(WINS_TO_MATCH);
    localparam logic [RW-1:0] RoundsMax = RW'(MAX_ROUNDS);
    localparam logic [BW-1:0] BlinkLast = BW'(BLINK_DIV - 1);

    logic start_rise, result_rise;

    rps_edge_detect u_start_edge (
        .clock   (clock),
        .reset_n (reset_n),
        .level   (start_match),
        .rise    (start_rise)
    );

    rps_edge_detect u_result_edge (
        .clock   (clock),
        .reset_n (reset_n),
        .level   (result_valid),
        .rise    (result_rise)
    );

    state_e        state_q, state_d;
    logic [SW-1:0] player_q, player_d, cpu_q, cpu_d;
    logic [RW-1:0] round_q, round_d;
    logic [BW-1:0] blink_q, blink_d;
    logic          err_q, err_d;
    logic          strobe_q, strobe_d;
    logic          active_q, active_d, won_q, won_d, lost_q, lost_d, draw_q, draw_d;
    logic          led_q, led_d;
    result_e       res;

    // State register
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= StIdle;
            player_q <= '0;
            cpu_q    <= '0;
            round_q  <= '0;
            blink_q  <= '0;
            err_q    <= 1'b0;
            strobe_q <= 1'b0;
            active_q <= 1'b0;
            won_q    <= 1'b0;
            lost_q   <= 1'b0;
            draw_q   <= 1'b0;
            led_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            player_q <= player_d;
            cpu_q    <= cpu_d;
            round_q  <= round_d;
            blink_q  <= blink_d;
            err_q    <= err_d;
            strobe_q <= strobe_d;
            active_q <= active_d;
            won_q    <= won_d;
            lost_q   <= lost_d;
            draw_q   <= draw_d;
            led_q    <= led_d;
        end
    end

    // Next-state and scoring; a restart wins over a coincident result edge.
    always_comb begin
        state_d  = state_q;
        player_d = player_q;
        cpu_d    = cpu_q;
        round_d  = round_q;
        err_d    = err_q;
        strobe_d = 1'b0;
        res      = decode_result(win_in, lose_in);

        if (start_rise) begin
            state_d  = StPlay;
            player_d = '0;
            cpu_d    = '0;
            round_d  = '0;
            err_d    = 1'b0;
        end else if (state_q == StPlay && result_rise) begin
            strobe_d = 1'b1;
            if (win_in && lose_in) err_d = 1'b1;
            case (res)
                RES_WIN:  if (player_q != WinsMax) player_d = player_q + 1'b1;
                RES_LOSE: if (cpu_q != WinsMax) cpu_d = cpu_q + 1'b1;
                default:  ;
            endcase
            if (round_q != RoundsMax) round_d = round_q + 1'b1;

            if (player_d == WinsMax)     state_d = StWon;
            else if (cpu_d == WinsMax)   state_d = StLost;
            else if (round_d == RoundsMax) state_d = StDraw;
        end
    end

    // Outputs are registered decodes of the next state so they line up with the counts.
    always_comb begin
        active_d = (state_d == StPlay);
        won_d    = (state_d == StWon);
        lost_d   = (state_d == StLost);
        draw_d   = (state_d == StDraw);
        blink_d  = '0;
        led_d    = 1'b0;

        if (state_d == StWon) begin
            if (state_q != StWon) begin
                led_d = 1'b1;
            end else if (blink_q == BlinkLast) begin
                led_d = ~led_q;
            end else begin
                blink_d = blink_q + 1'b1;
                led_d   = led_q;
            end
        end else if (state_d == StLost || state_d == StDraw) begin
            led_d = 1'b1;
        end
    end

    assign player_score = player_q;
    assign cpu_score    = cpu_q;
    assign round_count  = round_q;
    assign round_strobe = strobe_q;
    assign match_active = active_q;
    assign match_won    = won_q;
    assign match_lost   = lost_q;
    assign match_draw   = draw_q;
    assign result_led   = led_q;
    assign protocol_err = err_q;

endmodule

// File: tb/tb_rps_match_scorer.sv
// Directed self-checking bench for rps_match_scorer (3 wins, 9 rounds, blink every 4 cycles).
module tb_rps_match_scorer;

    logic       clock = 1'b0;
    logic       reset_n;
    logic       start_match, result_valid, win_in, lose_in;
    logic [1:0] player_score, cpu_score;
    logic [3:0] round_count;
    logic       round_strobe, match_active, match_won, match_lost, match_draw;
    logic       result_led, protocol_err;

    int checks = 0;
    int errors = 0;
    int strobes;

    rps_match_scorer #(
        .WINS_TO_MATCH (3),
        .MAX_ROUNDS    (9),
        .BLINK_DIV     (4)
    ) dut (
        .clock        (clock),
        .reset_n      (reset_n),
        .start_match  (start_match),
        .result_valid (result_valid),
        .win_in       (win_in),
        .lose_in      (lose_in),
        .player_score (player_score),
        .cpu_score    (cpu_score),
        .round_count  (round_count),
        .round_strobe (round_strobe),
        .match_active (match_active),
        .match_won    (match_won),
        .match_lost   (match_lost),
        .match_draw   (match_draw),
        .result_led   (result_led),
        .protocol_err (protocol_err)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one clock; outputs are stable 1 time unit after the edge.
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    // One low cycle then a result_valid rise; outputs after return reflect the scored round.
    task automatic do_round(input logic w, input logic l);
        result_valid = 1'b0;
        tick();
        win_in       = w;
        lose_in      = l;
        result_valid = 1'b1;
        tick();
        result_valid = 1'b0;
    endtask

    task automatic start();
        start_match = 1'b1;
        tick();
        start_match = 1'b0;
    endtask

    initial begin
        reset_n = 1'b0;
        start_match = 1'b0;
        result_valid = 1'b0;
        win_in = 1'b0;
        lose_in = 1'b0;
        ticks(2);
        check("rst_status", {match_active, match_won, match_lost, match_draw}, 4'b0000);
        check("rst_counts", {player_score, cpu_score, round_count}, 8'h00);
        check("rst_misc", {round_strobe, result_led, protocol_err}, 3'b000);
        reset_n = 1'b1;
        tick();

        // 1: three player wins, blinking LED
        start();
        check("t1_active", match_active, 1'b1);
        do_round(1'b1, 1'b0);
        check("t1_p1", player_score, 2'd1);
        check("t1_strobe", round_strobe, 1'b1);
        do_round(1'b1, 1'b0);
        check("t1_p2", player_score, 2'd2);
        check("t1_not_won", match_won, 1'b0);
        do_round(1'b1, 1'b0);
        check("t1_p3", player_score, 2'd3);
        check("t1_status", {match_active, match_won, match_lost, match_draw}, 4'b0100);
        check("t1_rounds", round_count, 4'd3);
        check("t1_led_entry", result_led, 1'b1);
        ticks(3);
        check("t1_led_hold", result_led, 1'b1);
        tick();
        check("t1_led_off", result_led, 1'b0);
        ticks(3);
        check("t1_led_off_hold", result_led, 1'b0);
        tick();
        check("t1_led_on", result_led, 1'b1);
        check("t1_still_won", match_won, 1'b1);

        // 2: lose, win, lose, lose
        start();
        check("t2_cleared", {player_score, cpu_score, round_count}, 8'h00);
        check("t2_led_clr", result_led, 1'b0);
        do_round(1'b0, 1'b1);
        do_round(1'b1, 1'b0);
        do_round(1'b0, 1'b1);
        check("t2_not_lost", match_lost, 1'b0);
        do_round(1'b0, 1'b1);
        check("t2_cpu", cpu_score, 2'd3);
        check("t2_player", player_score, 2'd1);
        check("t2_status", {match_active, match_won, match_lost, match_draw}, 4'b0010);
        check("t2_led", result_led, 1'b1);
        ticks(6);
        check("t2_led_solid", result_led, 1'b1);
        do_round(1'b1, 1'b0);
        check("t2_ignored", {player_score, round_count}, {2'd1, 4'd4});

        // 3: nine ties draw
        start();
        for (int i = 0; i < 8; i++) do_round(1'b0, 1'b0);
        check("t3_8_active", {match_active, match_draw}, 2'b10);
        check("t3_8_rounds", round_count, 4'd8);
        do_round(1'b0, 1'b0);
        check("t3_rounds", round_count, 4'd9);
        check("t3_scores", {player_score, cpu_score}, 4'h0);
        check("t3_status", {match_active, match_won, match_lost, match_draw}, 4'b0001);
        check("t3_led", result_led, 1'b1);

        // 4: result_valid held high counts once
        start();
        tick();
        win_in = 1'b1;
        lose_in = 1'b0;
        result_valid = 1'b1;
        strobes = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (round_strobe) strobes++;
        end
        result_valid = 1'b0;
        check("t4_strobes", strobes, 1);
        check("t4_rounds", round_count, 4'd1);
        check("t4_player", player_score, 2'd1);

        // 5: win and lose together
        do_round(1'b1, 1'b1);
        check("t5_err", protocol_err, 1'b1);
        check("t5_rounds", round_count, 4'd2);
        check("t5_scores", {player_score, cpu_score}, {2'd1, 2'd0});
        do_round(1'b1, 1'b0);
        check("t5_err_sticky", protocol_err, 1'b1);
        check("t5_p2", player_score, 2'd2);
        start();
        check("t5_err_clr", protocol_err, 1'b0);

        // 6: async reset mid-match, ignored IDLE edge, restart beats result
        do_round(1'b1, 1'b0);
        do_round(1'b1, 1'b0);
        check("t6_p2", player_score, 2'd2);
        reset_n = 1'b0;
        #2;
        check("t6_async_counts", {player_score, cpu_score, round_count}, 8'h00);
        check("t6_async_status", {match_active, round_strobe, result_led, protocol_err}, 4'h0);
        #1;
        reset_n = 1'b1;
        do_round(1'b1, 1'b0);
        check("t6_idle_ignored", {player_score, round_count, round_strobe, match_active},
              {2'd0, 4'd0, 1'b0, 1'b0});
        start();
        do_round(1'b1, 1'b0);
        check("t6_pre_restart", player_score, 2'd1);
        tick();
        start_match = 1'b1;
        result_valid = 1'b1;
        win_in = 1'b1;
        tick();
        start_match = 1'b0;
        result_valid = 1'b0;
        check("t6_restart_counts", {player_score, cpu_score, round_count}, 8'h00);
        check("t6_restart_flags", {round_strobe, match_active}, 2'b01);
        tick();
        check("t6_no_late_score", {round_count, round_strobe}, {4'd0, 1'b0});

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
